// File: rtl/scan_arb_pkg.sv
// scan_arb_pkg
//   Shared definitions for the scan-chain arbiter: the 2-bit arbiter state
//   encoding, the packed scan-drive bundle and the value the chain is driven
//   to whenever no requester owns it.
package scan_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_GUARD_IN  = 2'd1,
      ST_OWNED     = 2'd2,
      ST_GUARD_OUT = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic clk;
      logic data;
      logic select;
      logic latch_en;
   } scan_drive_t;

   // Chain parked: clock low, data low, select low, latch low.
   localparam scan_drive_t SCAN_IDLE = '{clk: 1'b0, data: 1'b0, select: 1'b0, latch_en: 1'b0};

   // Guard counter width, large enough for up to 255 guard cycles.
   localparam int GUARD_W = 8;

endpackage

// File: rtl/scan_arb_rr_pick.sv
// scan_arb_rr_pick
//   Combinational round-robin picker. Returns the first requester that is
//   both requesting and eligible, searching upward from rr_ptr with
//   wrap-around modulo NUM_REQ.
//   Ports:
//     req      in   NUM_REQ  request levels
//     eligible in   NUM_REQ  eligibility mask (1 = may win)
//     rr_ptr   in   2        search start index (< NUM_REQ)
//     winner   out  2        index of the winning requester
//     valid    out  1        a winner exists
module scan_arb_rr_pick #(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [1:0]         rr_ptr,
   output logic [1:0]         winner,
   output logic               valid
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [1:0]           offset;
   logic [2:0]           sum;

   // Rotate the candidate mask so bit 0 is the requester at rr_ptr.
   assign dbl = {2{req & eligible}} >> rr_ptr;
   assign rot = dbl[NUM_REQ-1:0];

   // Scan downward so the lowest set offset is the last one written.
   always_comb begin
      offset = 2'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) offset = 2'(k);
      end
   end

   assign valid  = |rot;
   assign sum    = {1'b0, rr_ptr} + {1'b0, offset};
   assign winner = (sum >= 3'(NUM_REQ)) ? 2'(sum - 3'(NUM_REQ)) : sum[1:0];

endmodule

// File: rtl/scan_chain_arbiter.sv
// scan_chain_arbiter
//   Grants a shared scan chain to one of NUM_REQ requesters at a time,
//   round-robin, with GUARD_CYCLES of parked chain before and after each
//   ownership and an optional hold timeout that locks out the offender
//   until it releases its request.
//   Ports:
//     clk, reset                     clock, async active-high reset
//     req[NUM_REQ]                   level requests
//     gnt[NUM_REQ]                   registered one-hot-or-zero grant
//     rq_scan_{clk,data,select,latch_en}[NUM_REQ]  per-requester chain drive
//     scan_{clk_out,data_out,select,latch_en}      registered chain drive
//     timeout_cfg[TMO_W]             max owned cycles, 0 disables
//     owner[2]                       current or last owner
//     busy                           registered, high when not IDLE
//     timeout_pulse                  one-cycle pulse on forced revoke
module scan_chain_arbiter
   import scan_arb_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int GUARD_CYCLES = 4,
   parameter int TMO_W        = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   input  logic [NUM_REQ-1:0] rq_scan_clk,
   input  logic [NUM_REQ-1:0] rq_scan_data,
   input  logic [NUM_REQ-1:0] rq_scan_select,
   input  logic [NUM_REQ-1:0] rq_scan_latch_en,
   output logic               scan_clk_out,
   output logic               scan_data_out,
   output logic               scan_select,
   output logic               scan_latch_en,
   input  logic [TMO_W-1:0]   timeout_cfg,
   output logic [1:0]         owner,
   output logic               busy,
   output logic               timeout_pulse
);

   localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);

   arb_state_t         state, state_n;
   logic [GUARD_W-1:0] gcnt, gcnt_n;
   logic [TMO_W-1:0]   hcnt, hcnt_n;
   logic [1:0]         owner_q, owner_n;
   logic [1:0]         rr_ptr, rr_ptr_n;
   logic [NUM_REQ-1:0] lockout, lockout_n;
   logic [NUM_REQ-1:0] owner_oh;
   logic               owner_req;
   logic               tmo_hit;
   logic [1:0]         pick_idx;
   logic               pick_vld;
   scan_drive_t        drive_n, drive_p1;

   assign owner_oh  = NUM_REQ'(1) << owner_q;
   assign owner_req = |(req & owner_oh);

   scan_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req      (req),
      .eligible (~lockout),
      .rr_ptr   (rr_ptr),
      .winner   (pick_idx),
      .valid    (pick_vld)
   );

   always_comb begin
      state_n   = state;
      gcnt_n    = gcnt;
      hcnt_n    = hcnt;
      owner_n   = owner_q;
      rr_ptr_n  = rr_ptr;
      tmo_hit   = 1'b0;
      // A lockout is forgiven on any cycle the requester lets go.
      lockout_n = lockout & req;
      case (state)
         ST_IDLE: begin
            if (pick_vld) begin
               owner_n = pick_idx;
               gcnt_n  = GUARD_LOAD;
               state_n = ST_GUARD_IN;
            end
         end
         ST_GUARD_IN: begin
            if (gcnt == '0) begin
               state_n = ST_OWNED;
               hcnt_n  = '0;
            end else begin
               gcnt_n = gcnt - 8'd1;
            end
         end
         ST_OWNED: begin
            // A voluntary release takes priority over a coincident timeout.
            if (!owner_req) begin
               state_n = ST_GUARD_OUT;
               gcnt_n  = GUARD_LOAD;
            end else if (timeout_cfg != '0 && hcnt == timeout_cfg - TMO_W'(1)) begin
               state_n   = ST_GUARD_OUT;
               gcnt_n    = GUARD_LOAD;
               tmo_hit   = 1'b1;
               lockout_n = lockout_n | owner_oh;
            end else if (hcnt != '1) begin
               hcnt_n = hcnt + TMO_W'(1);
            end
         end
         ST_GUARD_OUT: begin
            if (gcnt == '0) begin
               state_n  = ST_IDLE;
               rr_ptr_n = (owner_q == 2'(NUM_REQ - 1)) ? 2'd0 : owner_q + 2'd1;
            end else begin
               gcnt_n = gcnt - 8'd1;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // Chain follows the owner only while the current state is OWNED,
      // so the output lags the requester's drive by one cycle.
      drive_n = SCAN_IDLE;
      if (state == ST_OWNED) begin
         drive_n.clk      = |(rq_scan_clk      & owner_oh);
         drive_n.data     = |(rq_scan_data     & owner_oh);
         drive_n.select   = |(rq_scan_select   & owner_oh);
         drive_n.latch_en = |(rq_scan_latch_en & owner_oh);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         gcnt          <= '0;
         hcnt          <= '0;
         owner_q       <= '0;
         rr_ptr        <= '0;
         lockout       <= '0;
         gnt           <= '0;
         busy          <= 1'b0;
         timeout_pulse <= 1'b0;
         drive_p1      <= SCAN_IDLE;
      end else begin
         state         <= state_n;
         gcnt          <= gcnt_n;
         hcnt          <= hcnt_n;
         owner_q       <= owner_n;
         rr_ptr        <= rr_ptr_n;
         lockout       <= lockout_n;
         // owner never changes on the way into OWNED, so owner_oh is valid here.
         gnt           <= (state_n == ST_OWNED) ? owner_oh : '0;
         busy          <= (state_n != ST_IDLE);
         timeout_pulse <= tmo_hit;
         drive_p1      <= drive_n;
      end
   end

   assign owner         = owner_q;
   assign scan_clk_out  = drive_p1.clk;
   assign scan_data_out = drive_p1.data;
   assign scan_select   = drive_p1.select;
   assign scan_latch_en = drive_p1.latch_en;

endmodule

// File: tb/tb_scan_chain_arbiter.sv
// tb_scan_chain_arbiter
//   Self-checking bench for scan_chain_arbiter (NUM_REQ=3, GUARD_CYCLES=4).
//   A timestamp-based reference model predicts every output on every cycle;
//   a vector table and hand-written sequences add targeted checks.
module tb_scan_chain_arbiter;

   localparam int N  = 3;
   localparam int G  = 4;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req, gnt;
   logic [N-1:0]  rq_sc, rq_sd, rq_ss, rq_sl;
   logic          sco, sdo, sso, slo;
   logic [TW-1:0] tmo;
   logic [1:0]    owner;
   logic          busy, tpulse;

   always #5 clk = ~clk;

   scan_chain_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(G), .TMO_W(TW)) dut (
      .clk              (clk),
      .reset            (reset),
      .req              (req),
      .gnt              (gnt),
      .rq_scan_clk      (rq_sc),
      .rq_scan_data     (rq_sd),
      .rq_scan_select   (rq_ss),
      .rq_scan_latch_en (rq_sl),
      .scan_clk_out     (sco),
      .scan_data_out    (sdo),
      .scan_select      (sso),
      .scan_latch_en    (slo),
      .timeout_cfg      (tmo),
      .owner            (owner),
      .busy             (busy),
      .timeout_pulse    (tpulse)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (ownership timeline) ----------------
   // A tenure is described by the edge it was claimed (m_t0) and the edge it
   // ended (m_texit, -1 while still held). Everything else follows from the
   // fixed guard lengths.
   int       cyc_n = 0;
   bit       m_claim;
   int       m_t0, m_texit, m_own, m_rr;
   bit [N-1:0] m_lock;
   logic [N-1:0] e_gnt;
   logic     e_busy, e_pulse;
   logic [3:0] e_scan;

   task automatic model_reset();
      m_claim = 0; m_t0 = 0; m_texit = -1; m_own = 0; m_rr = 0; m_lock = '0;
      e_gnt = '0; e_busy = 0; e_pulse = 0; e_scan = '0;
   endtask

   task automatic model_edge();
      int e = cyc_n;
      bit was_owned = m_claim && (e - 1 >= m_t0 + G) && (m_texit < 0);
      bit [N-1:0] lock_next = m_lock & req;
      bit found = 0;
      e_pulse = 0;
      e_scan  = was_owned ? {rq_sc[m_own], rq_sd[m_own], rq_ss[m_own], rq_sl[m_own]} : 4'b0;
      if (!m_claim) begin
         for (int k = 0; k < N; k++) begin
            int i = (m_rr + k) % N;
            if (!found && req[i] && !m_lock[i]) begin
               found = 1; m_own = i;
            end
         end
         if (found) begin
            m_claim = 1; m_t0 = e; m_texit = -1;
         end
      end else if (was_owned) begin
         if (!req[m_own]) m_texit = e;
         else if (tmo != 0 && (e - m_t0 - G) == int'(tmo)) begin
            m_texit = e; e_pulse = 1; lock_next[m_own] = 1'b1;
         end
      end else if (m_texit >= 0 && e == m_texit + G) begin
         m_claim = 0;
         m_rr    = (m_own + 1) % N;
      end
      m_lock = lock_next;
      e_gnt  = (m_claim && e >= m_t0 + G && m_texit < 0) ? N'(1 << m_own) : '0;
      e_busy = m_claim;
   endtask

   function automatic logic [10:0] dut_vec();
      return {gnt, busy, owner, tpulse, sco, sdo, sso, slo};
   endfunction

   function automatic logic [10:0] exp_vec();
      return {e_gnt, e_busy, 2'(m_own), e_pulse, e_scan};
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc_n++;
      if (!reset) model_edge();
      #1;
      chk("cycle", 32'(dut_vec()), 32'(exp_vec()));
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      req = '0; rq_sc = '0; rq_sd = '0; rq_ss = '0; rq_sl = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'(dut_vec()), 32'd0);
      reset = 1'b0;
   endtask

   task automatic wait_gnt(input logic [N-1:0] g, input int budget, input string name);
      int i = 0;
      while (gnt !== g && i < budget) begin tick(); i++; end
      chk(name, 32'(gnt), 32'(g));
   endtask

   task automatic wait_idle(input int budget, input string name);
      int i = 0;
      while (busy !== 1'b0 && i < budget) begin tick(); i++; end
      chk(name, 32'(busy), 32'd0);
   endtask

   // ---------------- vector table: single grant with chain mirroring ----------------
   typedef struct {
      logic [N-1:0] req;
      logic         sclk;
      logic         ssel;
      logic [N-1:0] x_gnt;
      logic         x_busy;
      logic         x_sclk;
      logic         x_ssel;
   } vec_t;

   vec_t vt[14];

   initial begin
      int order[4];
      int ng, held, end_e, cnt, pul, gc, first;

      vt[0]  = '{3'b001, 0, 0, 3'b000, 1, 0, 0};
      vt[1]  = '{3'b001, 1, 0, 3'b000, 1, 0, 0};
      vt[2]  = '{3'b001, 0, 0, 3'b000, 1, 0, 0};
      vt[3]  = '{3'b001, 1, 1, 3'b000, 1, 0, 0};
      vt[4]  = '{3'b001, 1, 0, 3'b001, 1, 0, 0};
      vt[5]  = '{3'b001, 0, 1, 3'b001, 1, 0, 1};
      vt[6]  = '{3'b001, 1, 1, 3'b001, 1, 1, 1};
      vt[7]  = '{3'b001, 0, 1, 3'b001, 1, 0, 1};
      vt[8]  = '{3'b001, 1, 0, 3'b001, 1, 1, 0};
      vt[9]  = '{3'b000, 1, 1, 3'b000, 1, 1, 1};
      vt[10] = '{3'b000, 1, 1, 3'b000, 1, 0, 0};
      vt[11] = '{3'b000, 0, 0, 3'b000, 1, 0, 0};
      vt[12] = '{3'b000, 0, 0, 3'b000, 1, 0, 0};
      vt[13] = '{3'b000, 0, 0, 3'b000, 0, 0, 0};

      tmo = '0;
      apply_reset();
      for (int r = 0; r < 14; r++) begin
         req   = vt[r].req;
         rq_sc = {2'b00, vt[r].sclk};
         rq_ss = {2'b00, vt[r].ssel};
         tick();
         chk($sformatf("table_row%0d", r), {gnt, busy, sco, sso},
             {vt[r].x_gnt, vt[r].x_busy, vt[r].x_sclk, vt[r].x_ssel});
      end

      // ---------------- round-robin rotation with voluntary release ----------------
      apply_reset();
      req = 3'b111; ng = 0; held = 0; end_e = -1;
      for (int i = 0; i < 200 && ng < 4; i++) begin
         tick();
         if (gnt != '0) begin
            if (held == 0) begin
               order[ng] = int'(owner);
               ng++;
               if (end_e >= 0) chk("rr_gap", 32'(cyc_n - end_e), 32'(2 * G + 1));
            end
            held++;
            if (held == 10) req = req & ~gnt;
         end else if (held > 0) begin
            held = 0; end_e = cyc_n; req = 3'b111;
         end
      end
      chk("rr_grants", 32'(ng), 32'd4);
      chk("rr_order", {8'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3])}, 32'h00010200);

      // ---------------- hold timeout and lockout ----------------
      apply_reset();
      tmo = 16'd8; req = 3'b010; cnt = 0; pul = 0;
      repeat (60) begin
         tick();
         if (gnt == 3'b010) cnt++;
         pul += int'(tpulse);
      end
      chk("tmo_hold", 32'(cnt), 32'd8);
      chk("tmo_pulse", 32'(pul), 32'd1);
      chk("tmo_locked", 32'(busy), 32'd0);
      req = 3'b000;
      tick();
      req = 3'b010;
      wait_gnt(3'b010, 20, "tmo_regrant");

      // ---------------- release coinciding with timeout ----------------
      apply_reset();
      tmo = 16'd8; req = 3'b100; cnt = 0; pul = 0;
      for (int i = 0; i < 40 && cnt < 8; i++) begin
         tick();
         pul += int'(tpulse);
         if (gnt == 3'b100) cnt++;
      end
      chk("coin_hold", 32'(cnt), 32'd8);
      req = 3'b000;
      tick();
      pul += int'(tpulse);
      gc = (busy && gnt == '0) ? 1 : 0;
      req = 3'b100;
      for (int i = 0; i < 20 && busy; i++) begin
         tick();
         pul += int'(tpulse);
         if (busy && gnt == '0) gc++;
      end
      chk("coin_guard_out", 32'(gc), 32'(G));
      chk("coin_no_pulse", 32'(pul), 32'd0);
      wait_gnt(3'b100, 20, "coin_no_lockout");

      // ---------------- asynchronous reset mid-ownership ----------------
      apply_reset();
      tmo = '0; req = 3'b001; rq_ss = 3'b001;
      begin
         int i = 0;
         while (sso !== 1'b1 && i < 20) begin tick(); i++; end
      end
      chk("rst_pre_select", 32'(sso), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_gnt", 32'(gnt), 32'd0);
      chk("rst_async_select", 32'(sso), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0; req = 3'b010; rq_ss = '0; first = -1;
      for (int k = 1; k <= G + 3; k++) begin
         tick();
         if (gnt == 3'b010 && first < 0) first = k;
      end
      chk("rst_fresh_latency", 32'(first), 32'(G + 1));

      // ---------------- wrap-around from rr_ptr=2 ----------------
      apply_reset();
      req = 3'b010;
      wait_gnt(3'b010, 20, "wrap_setup");
      req = 3'b000;
      wait_idle(20, "wrap_idle");
      req = 3'b011;
      wait_gnt(3'b001, 20, "wrap_pick");

      // ---------------- randomized traffic against the model ----------------
      apply_reset();
      tmo = 16'(5);
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
         end
         rq_sc = N'($urandom); rq_sd = N'($urandom);
         rq_ss = N'($urandom); rq_sl = N'($urandom);
         if ($urandom_range(0, 199) == 0) tmo = 16'($urandom_range(0, 12));
         if (i == 1500) apply_reset();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
